// File: rtl/bump_nav_fsm.sv
// bump_nav_fsm: rover bump/ground navigation controller.
// It has timed BACKUP and TURN dwell phases, remembers which side was bumped,
// and escalates to a SPIN manoeuvre when too many bumps land in one clear window.
// Ports:
//   clk           - rising-edge clock
//   reset         - synchronous, active-high
//   bump_left     - left bumper contact (level)
//   bump_right    - right bumper contact (level)
//   ground_detect - 1 = floor present
//   state         - current state code (registered)
//   bump_count    - bumps counted in the current clear window (registered)
//   stuck         - one-cycle pulse on the first SPIN cycle (registered)
module bump_nav_fsm #(
  parameter int unsigned BACKUP_CYCLES = 4,
  parameter int unsigned TURN_CYCLES   = 8,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned STUCK_LIMIT   = 3,
  parameter int unsigned CLEAR_CYCLES  = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               bump_left,
  input  logic                               bump_right,
  input  logic                               ground_detect,
  output logic [2:0]                         state,
  output logic [$clog2(STUCK_LIMIT+1)-1:0]   bump_count,
  output logic                               stuck
);

  localparam int unsigned BW = $clog2(STUCK_LIMIT + 1);

  // Dwell timer loads N-1 so the state is visible for exactly N cycles.
  localparam logic [CNT_W-1:0] BACKUP_LOAD = CNT_W'(BACKUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SPIN_LOAD   = CNT_W'(2 * TURN_CYCLES - 1);
  localparam logic [CNT_W:0]   CLEAR_END   = (CNT_W+1)'(CLEAR_CYCLES);
  localparam logic [BW-1:0]    COUNT_MAX   = BW'(STUCK_LIMIT);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FORWARD    = 3'd1,
    BACKUP     = 3'd2,
    TURN_LEFT  = 3'd3,
    TURN_RIGHT = 3'd4,
    SPIN       = 3'd5
  } state_t;

  state_t           cur_state, nxt_state;
  state_t           target, nxt_target;
  logic [BW-1:0]    count, nxt_count, count_inc;
  logic [CNT_W-1:0] dwell, nxt_dwell;
  logic [CNT_W-1:0] clear_cnt, nxt_clear;
  logic [CNT_W:0]   clear_inc;
  logic             nxt_stuck;

  assign state      = cur_state;
  assign bump_count = count;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= IDLE;
      target    <= TURN_LEFT;
      count     <= '0;
      dwell     <= '0;
      clear_cnt <= '0;
      stuck     <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      target    <= nxt_target;
      count     <= nxt_count;
      dwell     <= nxt_dwell;
      clear_cnt <= nxt_clear;
      stuck     <= nxt_stuck;
    end
  end

  // Next-state, counter and pulse logic.
  always_comb begin
    nxt_state  = cur_state;
    nxt_target = target;
    nxt_count  = count;
    nxt_dwell  = dwell;
    nxt_clear  = '0;
    nxt_stuck  = 1'b0;

    count_inc = (count == COUNT_MAX) ? count : count + BW'(1);
    clear_inc = {1'b0, clear_cnt} + (CNT_W+1)'(1);

    // Ground loss overrides everything outside IDLE, including a final dwell cycle.
    if (cur_state != IDLE && !ground_detect) begin
      nxt_state = IDLE;
      nxt_count = '0;
      nxt_dwell = '0;
    end else begin
      case (cur_state)
        IDLE: begin
          if (ground_detect) nxt_state = FORWARD;
        end
        FORWARD: begin
          if (bump_left || bump_right) begin
            nxt_state = BACKUP;
            nxt_count = count_inc;
            nxt_dwell = BACKUP_LOAD;
            if (count_inc == COUNT_MAX) nxt_target = SPIN;
            else if (bump_left)         nxt_target = TURN_RIGHT;
            else                        nxt_target = TURN_LEFT;
          end else if (clear_inc == CLEAR_END) begin
            nxt_count = '0;
          end else begin
            nxt_clear = clear_inc[CNT_W-1:0];
          end
        end
        BACKUP: begin
          if (dwell == '0) begin
            nxt_state = target;
            nxt_dwell = (target == SPIN) ? SPIN_LOAD : TURN_LOAD;
          end else begin
            nxt_dwell = dwell - CNT_W'(1);
          end
        end
        TURN_LEFT, TURN_RIGHT: begin
          if (dwell == '0) nxt_state = FORWARD;
          else             nxt_dwell = dwell - CNT_W'(1);
        end
        SPIN: begin
          if (dwell == '0) begin
            nxt_state = FORWARD;
            nxt_count = '0;
          end else begin
            nxt_dwell = dwell - CNT_W'(1);
          end
        end
        default: begin
          nxt_state = IDLE;
          nxt_count = '0;
          nxt_dwell = '0;
        end
      endcase
    end

    // Pulse only when SPIN is actually entered (not when aborted on entry).
    nxt_stuck = (nxt_state == SPIN) && (cur_state != SPIN);
  end

endmodule

// File: doc/bump_nav_fsm.md
# bump_nav_fsm

Parametrised successor to the four-state bump/ground rover controller. It adds timed BACKUP and TURN dwell phases, bump-direction memory and a stuck-detection escalation to a SPIN manoeuvre. It sits between the debounced bumper/ground sensor inputs and the motor command decoder, which consumes `state`.

## Interface
- `BACKUP_CYCLES`, default 4: cycles spent in BACKUP; must be ≥1.
- `TURN_CYCLES`, default 8: cycles spent in TURN_LEFT/TURN_RIGHT; SPIN lasts 2*TURN_CYCLES; must be ≥1.
- `CNT_W`, default 8: dwell-timer width; requires BACKUP_CYCLES ≤ 2^CNT_W and 2*TURN_CYCLES ≤ 2^CNT_W.
- `STUCK_LIMIT`, default 3: bumps within one clear window that trigger SPIN; must be ≥1.
- `CLEAR_CYCLES`, default 16: consecutive bump-free FORWARD cycles that clear the bump count; must be ≥1 and < 2^CNT_W.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `bump_left` in 1: left bumper contact, level.
- `bump_right` in 1: right bumper contact, level.
- `ground_detect` in 1: 1 = floor present.
- `state` out 3: current state (registered).
- `bump_count` out BW = $clog2(STUCK_LIMIT+1): bumps in the current window.
- `stuck` out 1: one-cycle pulse on the first cycle of SPIN.

## Operation
- State encoding: IDLE=0, FORWARD=1, BACKUP=2, TURN_LEFT=3, TURN_RIGHT=4, SPIN=5. Codes 6 and 7 go to IDLE on the next cycle.
- Priority 1: reset.
  - state=IDLE, bump_count=0, stuck=0; dwell and clear timers=0; turn target=TURN_LEFT.
- Priority 2: `ground_detect`=0 in any non-IDLE state.
  - Next state is IDLE. bump_count and timers clear.
  - An in-progress dwell is abandoned.
- IDLE: `ground_detect`=1 -> FORWARD.
- FORWARD:
  - `bump_left` or `bump_right` -> BACKUP. bump_count increments, saturating at STUCK_LIMIT.
  - Turn target is latched on the bump:
    - If the new bump_count == STUCK_LIMIT: SPIN.
    - Else if `bump_left` (including both bumpers): TURN_RIGHT.
    - Else: TURN_LEFT.
  - No bump: the clear timer increments. When it reaches CLEAR_CYCLES, bump_count and the clear timer go to 0 on that edge.
  - The clear timer resets to 0 on any bump or on leaving FORWARD.
- BACKUP: exactly BACKUP_CYCLES cycles, then the latched target.
- TURN_LEFT/TURN_RIGHT: exactly TURN_CYCLES cycles, then FORWARD. bump_count is retained.
- SPIN: exactly 2*TURN_CYCLES cycles, then FORWARD. bump_count clears on SPIN exit.
- Bumper inputs are ignored outside FORWARD. No re-trigger during BACKUP, TURN or SPIN.
- Dwell timer:
  - Loads N-1 on the edge that enters a timed state.
  - Counts down each cycle.
  - The state exits on the edge where the timer is 0.

## Timing
- All outputs are registered. Every input is sampled on a rising edge and takes effect on `state` after that same edge (1-cycle latency).
- Dwell is exact: a timed state is visible on `state` for exactly N consecutive cycles.
- `stuck`:
  - Goes high in the first cycle where state=SPIN, low the next cycle.
  - Stays 0 if SPIN is aborted by ground loss on its entry edge.
- Simultaneous events:
  - Ground loss + bump in FORWARD -> IDLE, bump not counted.
  - Ground loss on a dwell's final cycle -> IDLE.
- Reset mid-dwell: IDLE on the next cycle, all counters 0.
- bump_count saturates and never wraps. With STUCK_LIMIT=1, every bump leads to SPIN.

## Test plan
1. Reset with `ground_detect`=1, then deassert reset -> state=0 for 1 cycle, then FORWARD; bump_count=0, stuck=0.
2. In FORWARD, pulse `bump_left` for 1 cycle -> BACKUP for 4 cycles, TURN_RIGHT (4) for 8 cycles, then FORWARD; bump_count=1.
   - Repeat with `bump_right` -> TURN_LEFT (3).
   - Repeat with both bumpers -> TURN_RIGHT.
3. Three bumps, each issued in FORWARD less than 16 cycles apart -> the third bump gives BACKUP for 4 cycles, then SPIN for 16 cycles with stuck=1 only on the first SPIN cycle, then FORWARD with bump_count=0.
4. One bump, then 16 bump-free FORWARD cycles -> bump_count returns to 0. A bump after only 15 cycles leaves bump_count=2.
5. Drop `ground_detect` on cycle 3 of TURN_RIGHT -> IDLE on the next cycle with bump_count=0. Holding a bumper during BACKUP has no effect on state or bump_count.
6. Assert reset during SPIN -> IDLE on the next cycle with stuck=0 and bump_count=0.
   - Regression on parameters: BACKUP_CYCLES=1, TURN_CYCLES=1, STUCK_LIMIT=1 -> dwell lengths 1/1/2, every bump leads to SPIN.
